// File: rtl/rpn_stack_engine.sv
// Reverse-Polish stack engine: top-of-stack in a register, the rest in a single-port
// array, each command walks IDLE -> READ -> EXEC -> WRITE.
module rpn_stack_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_data,
    input  logic                       clr_err,
    output logic                       done,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       carry,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] TWO     = CW'(2);
    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_UNDER = 2'b01;
    localparam logic [1:0] E_OVER  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
    typedef enum logic [2:0] {
        OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DUP, OP_SWAP
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [WIDTH-1:0] data_q, nos_q, top_q;
    logic [CW-1:0]    count_q;
    logic             carry_q, err_q;
    logic [1:0]       err_code_q;

    // EXEC results, held so WRITE only has to commit them
    logic [WIDTH-1:0] res_top_q, res_top_d;
    logic [CW-1:0]    res_cnt_q, res_cnt_d;
    logic             res_c_q, res_c_d;
    logic             res_cupd_q, res_cupd_d;
    logic             res_wen_q, res_wen_d;
    logic [AW-1:0]    res_waddr_q, res_waddr_d;
    logic [1:0]       res_err_q, res_err_d;

    logic [WIDTH-1:0] mem [0:DEPTH-2];
    logic [CW-1:0]    cm1, cm2;
    logic [WIDTH:0]   sum, diff;

    assign cm1  = count_q - ONE;
    assign cm2  = count_q - TWO;
    assign sum  = {1'b0, nos_q} + {1'b0, top_q};
    assign diff = {1'b0, nos_q} - {1'b0, top_q};

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_WRITE);
    assign top       = top_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign carry     = carry_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_top_d   = top_q;
        res_cnt_d   = count_q;
        res_c_d     = carry_q;
        res_cupd_d  = 1'b0;
        res_wen_d   = 1'b0;
        res_waddr_d = cm1[AW-1:0];
        res_err_d   = E_NONE;
        unique case (op_q)
            OP_PUSH: begin
                if (full) res_err_d = E_OVER;
                else begin
                    res_wen_d = !empty;
                    res_top_d = data_q;
                    res_cnt_d = count_q + ONE;
                end
            end
            OP_POP: begin
                if (empty) res_err_d = E_UNDER;
                else begin
                    res_top_d = (count_q == ONE) ? '0 : nos_q;
                    res_cnt_d = cm1;
                end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                if (count_q < TWO) res_err_d = E_UNDER;
                else begin
                    res_cnt_d = cm1;
                    if (op_q == OP_ADD) begin
                        {res_c_d, res_top_d} = sum;
                        res_cupd_d = 1'b1;
                    end else if (op_q == OP_SUB) begin
                        {res_c_d, res_top_d} = diff;
                        res_cupd_d = 1'b1;
                    end else if (op_q == OP_AND) begin
                        res_top_d = nos_q & top_q;
                    end else begin
                        res_top_d = nos_q | top_q;
                    end
                end
            end
            OP_DUP: begin
                if (empty) res_err_d = E_UNDER;
                else if (full) res_err_d = E_OVER;
                else begin
                    res_wen_d = 1'b1;
                    res_cnt_d = count_q + ONE;
                end
            end
            OP_SWAP: begin
                if (count_q < TWO) res_err_d = E_UNDER;
                else begin
                    res_wen_d   = 1'b1;
                    res_waddr_d = cm2[AW-1:0];
                    res_top_d   = nos_q;
                end
            end
            default: ;
        endcase
    end

    // Every array write stores the old top, so the write data is simply top_q
    always_ff @(posedge CLOCK_50) begin
        if (state_q == S_READ) nos_q <= mem[cm2[AW-1:0]];
        if (state_q == S_WRITE && res_wen_q && !reset) mem[res_waddr_q] <= top_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            top_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= E_NONE;
            res_top_q   <= '0;
            res_cnt_q   <= '0;
            res_c_q     <= 1'b0;
            res_cupd_q  <= 1'b0;
            res_wen_q   <= 1'b0;
            res_waddr_q <= '0;
            res_err_q   <= E_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid) begin
                op_q   <= op_t'(cmd_op);
                data_q <= cmd_data;
            end
            if (state_q == S_EXEC) begin
                res_top_q   <= res_top_d;
                res_cnt_q   <= res_cnt_d;
                res_c_q     <= res_c_d;
                res_cupd_q  <= res_cupd_d;
                res_wen_q   <= res_wen_d;
                res_waddr_q <= res_waddr_d;
                res_err_q   <= res_err_d;
            end
            if (clr_err) begin
                err_q      <= 1'b0;
                err_code_q <= E_NONE;
            end
            // A same-cycle clear counts as having happened first, so the new code lands
            if (state_q == S_WRITE) begin
                if (res_err_q != E_NONE) begin
                    err_q <= 1'b1;
                    if (!err_q || clr_err) err_code_q <= res_err_q;
                end else begin
                    top_q   <= res_top_q;
                    count_q <= res_cnt_q;
                    if (res_cupd_q) carry_q <= res_c_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// Scoreboard bench for rpn_stack_engine: a queue-based stack model predicts each
// command's outcome; a monitor checks latency and committed state on every done.
module tb_rpn_stack_engine;
    localparam int W = 8;
    localparam int D = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op   = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic       clr_err  = 1'b0;
    logic       done;
    logic [W-1:0] top;
    logic [$clog2(D+1)-1:0] count;
    logic       empty, full, carry, err;
    logic [1:0] err_code;

    rpn_stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .clr_err(clr_err), .done(done), .top(top),
        .count(count), .empty(empty), .full(full), .carry(carry), .err(err), .err_code(err_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int         acc;
        int         top;
        int         cnt;
        bit         c;
        bit         e;
        int         code;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: stack as a queue, bottom first
    int stk[$];
    bit mc = 0;
    bit me = 0;
    int mcode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        mc = 0;
        me = 0;
        mcode = 0;
    endtask

    task automatic model_step(input int op, input int data);
        int n, s, t, code;
        n = stk.size();
        code = 0;
        case (op)
            0: if (n == D) code = 2; else stk.push_back(data);
            1: if (n == 0) code = 1; else void'(stk.pop_back());
            2, 3, 4, 5: begin
                if (n < 2) code = 1;
                else begin
                    t = stk.pop_back();
                    s = stk.pop_back();
                    case (op)
                        2: begin mc = (s + t) > 255; stk.push_back((s + t) % 256); end
                        3: begin mc = s < t;         stk.push_back((s - t + 256) % 256); end
                        4: stk.push_back(s & t);
                        default: stk.push_back(s | t);
                    endcase
                end
            end
            6: if (n == 0) code = 1; else if (n == D) code = 2; else stk.push_back(stk[$]);
            default: begin
                if (n < 2) code = 1;
                else begin
                    t = stk.pop_back();
                    s = stk.pop_back();
                    stk.push_back(t);
                    stk.push_back(s);
                end
            end
        endcase
        if (code != 0) begin
            if (!me) mcode = code;
            me = 1;
        end
    endtask

    task automatic issue(input int op, input int data);
        exp_t e;
        int w;
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = W'(data);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", int'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        model_step(op, data);
        e.acc  = cyc;
        e.top  = (stk.size() != 0) ? stk[$] : 0;
        e.cnt  = stk.size();
        e.c    = mc;
        e.e    = me;
        e.code = mcode;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sbq.size() != 0 || !cmd_ready) && w < 50) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, ready=%0b", sbq.size(), cmd_ready);
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic clear_err();
        drain();
        @(negedge CLOCK_50);
        clr_err = 1'b1;
        @(negedge CLOCK_50);
        clr_err = 1'b0;
        me = 0;
        mcode = 0;
        chk("clr_err", int'(err), 0);
        chk("clr_err_code", int'(err_code), 0);
    endtask

    // Monitor: done must fall in the 3rd cycle after acceptance; state is checked after commit
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (done === 1'b1 && !reset) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("done_latency", cyc - mon_e.acc, 2);
                    @(posedge CLOCK_50);
                    #1;
                    chk("top", int'(top), mon_e.top);
                    chk("count", int'(count), mon_e.cnt);
                    chk("empty", int'(empty), int'(mon_e.cnt == 0));
                    chk("full", int'(full), int'(mon_e.cnt == D));
                    chk("carry", int'(carry), int'(mon_e.c));
                    chk("err", int'(err), int'(mon_e.e));
                    chk("err_code", int'(err_code), mon_e.code);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_top", int'(top), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();

        // add with no carry
        issue(0, 8'h05); issue(0, 8'h03); issue(2, 0);
        // sub with borrow, then add with carry
        do_reset();
        issue(0, 8'h03); issue(0, 8'h05); issue(3, 0); issue(0, 8'hFF); issue(2, 0);
        // fill, overflow, then pop to empty
        do_reset();
        issue(0, 1); issue(0, 2); issue(0, 3); issue(0, 4); issue(0, 9);
        drain();
        chk("full_after_ovf", int'(full), 1);
        chk("ovf_code", int'(err_code), 2);
        repeat (4) issue(1, 0);
        drain();
        chk("empty_after_pops", int'(empty), 1);
        // underflow code is sticky across a later good command, then cleared
        do_reset();
        issue(1, 0); issue(0, 8'hFF);
        drain();
        chk("uf_code_held", int'(err_code), 1);
        clear_err();
        // swap / dup / pop
        do_reset();
        issue(0, 8'hAA); issue(0, 8'h55); issue(7, 0); issue(6, 0); issue(1, 0); issue(1, 0);
        // reset during EXEC aborts the command
        do_reset();
        issue(0, 1); issue(0, 2);
        drain();
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_count", int'(count), 0);
        chk("abort_top", int'(top), 0);
        chk("abort_done", int'(done), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();

        // random traffic, push-biased so the stack visits every depth
        repeat (300) begin
            if ($urandom_range(0, 9) < 3) op = 0;
            else op = $urandom_range(1, 7);
            if ($urandom_range(0, 15) == 0) clear_err();
            issue(op, $urandom_range(0, 255));
        end
        drain();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
